// File: rtl/as_is_txq_if.sv
// as_is_txq_if -- AXI-stream style beat bundle used on both sides of as_is_txq.
//   tdata  pDATA_WIDTH                   beat data
//   tupsb  pUSER_PROJECT_SIDEBAND_WIDTH  user-project sideband
//   tstrb  pDATA_WIDTH/8                 byte strobes
//   tkeep  pDATA_WIDTH/8                 byte keeps
//   tlast  1                             last beat of packet
//   tid    2                             source id (00 user project, 01 axilite, 10 logic analyzer)
//   tuser  2                             user bits
//   tvalid 1                             beat valid
//   tready 1                             sink accepts
// master drives the payload and tvalid, slave drives tready.
interface as_is_txq_if #(
   parameter int unsigned pDATA_WIDTH                  = 32,
   parameter int unsigned pUSER_PROJECT_SIDEBAND_WIDTH = 5
);
   logic [pDATA_WIDTH-1:0]                  tdata;
   logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] tupsb;
   logic [pDATA_WIDTH/8-1:0]                tstrb;
   logic [pDATA_WIDTH/8-1:0]                tkeep;
   logic                                    tlast;
   logic [1:0]                              tid;
   logic [1:0]                              tuser;
   logic                                    tvalid;
   logic                                    tready;

   modport master (output tdata, tupsb, tstrb, tkeep, tlast, tid, tuser, tvalid,
                   input  tready);
   modport slave  (input  tdata, tupsb, tstrb, tkeep, tlast, tid, tuser, tvalid,
                   output tready);
endinterface

// File: rtl/as_is_txq.sv
// as_is_txq -- transmit queue between the stream switch upstream path and IO serdes.
// Stores whole beats (all stream fields) in a pDEPTH-entry circular buffer with
// one cycle of latency, tracks occupancy and stored packet count, and optionally
// watches for a stalled egress.
// Ports:
//   axis_clk    sole clock, rising edge
//   axis_rst    synchronous, active-high reset
//   s           slave stream from the stream switch (s.tready = room and not in reset)
//   m           master stream towards IO serdes (payload forced to 0 while !m.tvalid)
//   level       occupied entries
//   pkt_cnt     stored tlast beats
//   stall_clr   clears stall_flag
//   stall_flag  sticky: m.tvalid held without m.tready for pSTALL_CYC cycles
// Build option: define AS_IS_TXQ_STALL_MON_EN to include the stall monitor;
// otherwise stall_flag is tied to 0 and stall_clr is ignored.
module as_is_txq #(
   parameter int unsigned pDATA_WIDTH                  = 32,
   parameter int unsigned pUSER_PROJECT_SIDEBAND_WIDTH = 5,
   parameter int unsigned pDEPTH                       = 8,
   parameter int unsigned pSTALL_CYC                   = 256
) (
   input  logic                     axis_clk,
   input  logic                     axis_rst,
   as_is_txq_if.slave               s,
   as_is_txq_if.master              m,
   output logic [$clog2(pDEPTH):0]  level,
   output logic [$clog2(pDEPTH):0]  pkt_cnt,
   input  logic                     stall_clr,
   output logic                     stall_flag
);
   localparam int unsigned AW = $clog2(pDEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned SW = pDATA_WIDTH / 8;

   typedef struct packed {
      logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] tupsb;
      logic [pDATA_WIDTH-1:0]                  tdata;
      logic [SW-1:0]                           tstrb;
      logic [SW-1:0]                           tkeep;
      logic                                    tlast;
      logic [1:0]                              tid;
      logic [1:0]                              tuser;
   } entry_t;

   entry_t          mem [pDEPTH];
   entry_t          wr_entry;
   entry_t          head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push;
   logic            pop;

   // Ready depends only on occupancy, never on m.tready: a full queue stays
   // closed even in a cycle that pops.
   assign s.tready = (level < LW'(pDEPTH)) && !axis_rst;
   assign m.tvalid = (level != '0);
   assign push     = s.tvalid && s.tready;
   assign pop      = m.tvalid && m.tready;

   always_comb begin
      wr_entry       = '0;
      wr_entry.tupsb = s.tupsb;
      wr_entry.tdata = s.tdata;
      wr_entry.tstrb = s.tstrb;
      wr_entry.tkeep = s.tkeep;
      wr_entry.tlast = s.tlast;
      wr_entry.tid   = s.tid;
      wr_entry.tuser = s.tuser;
   end

   assign head = mem[rd_ptr];

   always_comb begin
      m.tupsb = '0;
      m.tdata = '0;
      m.tstrb = '0;
      m.tkeep = '0;
      m.tlast = 1'b0;
      m.tid   = '0;
      m.tuser = '0;
      if (m.tvalid) begin
         m.tupsb = head.tupsb;
         m.tdata = head.tdata;
         m.tstrb = head.tstrb;
         m.tkeep = head.tkeep;
         m.tlast = head.tlast;
         m.tid   = head.tid;
         m.tuser = head.tuser;
      end
   end

   // Storage carries no reset; clearing the pointers and level discards it.
   always_ff @(posedge axis_clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         pkt_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         case ({push && s.tlast, pop && head.tlast})
            2'b10:   pkt_cnt <= pkt_cnt + LW'(1);
            2'b01:   pkt_cnt <= pkt_cnt - LW'(1);
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

`ifdef AS_IS_TXQ_STALL_MON_EN
   localparam int unsigned CW = $clog2(pSTALL_CYC + 1);
   localparam logic [CW-1:0] STALL_MAX = CW'(pSTALL_CYC);

   logic [CW-1:0] stall_cnt;
   logic          stalled;

   assign stalled = m.tvalid && !m.tready;

   // Flag sets only on the transition into saturation, so stall_clr works
   // while the stall persists; a set on the same edge beats the clear.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         stall_cnt  <= '0;
         stall_flag <= 1'b0;
      end else begin
         if (!stalled)                    stall_cnt <= '0;
         else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + CW'(1);
         if (stalled && stall_cnt == STALL_MAX - CW'(1)) stall_flag <= 1'b1;
         else if (stall_clr)                             stall_flag <= 1'b0;
      end
   end
`else
   logic unused_stall_clr;
   assign unused_stall_clr = stall_clr;
   assign stall_flag       = 1'b0;
`endif
endmodule
